// File: rtl/lsu_req_queue_if.sv
// Request, tbus and response signals of the LSU request queue.
// The slave view belongs to the queue; the master view drives it.
`ifndef TBUS_RANGE
`define TBUS_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'd1
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd2
`endif

interface lsu_req_queue_if #(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic              req_is_store;
    logic              req_is_unsigned;
    logic [3:0]        req_ls_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              tbus_index_valid;
    logic              tbus_index_ready;
    logic [ADDR_W-1:0] tbus_index;
    logic [`TBUS_RANGE] tbus_operation_type;
    logic [63:0]       tbus_write_data;
    logic [63:0]       tbus_write_mask;
    logic              tbus_operation_done;
    logic [63:0]       tbus_read_data;

    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic [63:0]       resp_data;
    logic              resp_mmio;
    logic              resp_misalign;

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_is_unsigned,
        input  req_ls_size, req_addr, req_wdata, req_tag,
        output req_ready,
        output tbus_index_valid, tbus_index, tbus_operation_type,
        output tbus_write_data, tbus_write_mask,
        input  tbus_index_ready, tbus_operation_done, tbus_read_data,
        output resp_valid, resp_tag, resp_data, resp_mmio, resp_misalign
    );

    modport master (
        output req_valid, req_is_load, req_is_store, req_is_unsigned,
        output req_ls_size, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  tbus_index_valid, tbus_index, tbus_operation_type,
        input  tbus_write_data, tbus_write_mask,
        output tbus_index_ready, tbus_operation_done, tbus_read_data,
        input  resp_valid, resp_tag, resp_data, resp_mmio, resp_misalign
    );
endinterface

// File: rtl/lsu_req_queue.sv
// In-order load/store queue in front of the tbus with several ops in flight.
// MMIO and misaligned requests skip the bus and answer in program order.
module lsu_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 6,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 'h30000000,
    parameter logic [ADDR_W-1:0] MMIO_LIMIT = 'h40700000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic flush,
    output logic busy,
    lsu_req_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [63:0]       r_wdata [DEPTH];
    logic [TAG_W-1:0]  r_tag [DEPTH];
    logic [3:0]        r_size [DEPTH];
    logic              r_load [DEPTH];
    logic              r_uns [DEPTH];
    logic              r_mmio [DEPTH];
    logic              r_mis [DEPTH];

    logic [PW-1:0] r_head, r_issue, r_tail;
    logic [CW-1:0] r_count, r_infl;

    logic              r_bv;
    logic [ADDR_W-1:0] r_bidx;
    logic [`TBUS_RANGE] r_bop;
    logic [63:0]       r_bdata, r_bmask;

    logic              r_rv;
    logic [TAG_W-1:0]  r_rtag;
    logic [63:0]       r_rdata;
    logic              r_rmmio, r_rmis;

    logic w_push, w_fire, w_done, w_byp, w_pop;
    logic w_req_mmio, w_req_mis, w_onehot;
    logic [3:0] w_rsz;
    logic [PW-1:0] w_head_nxt, w_issue_nxt, w_tail_nxt;
    logic [CW-1:0] w_count_nxt, w_infl_nxt;

    assign bus.req_ready = (r_count != FULL) & ~flush;
    assign w_push = bus.req_valid & bus.req_ready;
    assign w_fire = r_bv & bus.tbus_index_ready;
    assign w_done = bus.tbus_operation_done & (r_infl != '0);
    // nothing in flight means issue == head, so the bypass entry is oldest
    assign w_byp = (r_infl == '0) & (r_count != '0) & ~flush
                 & (r_mmio[r_issue] | r_mis[r_issue]);
    assign w_pop = w_done | w_byp;

    assign w_rsz = bus.req_ls_size;
    assign w_onehot = (w_rsz != 4'd0) & ((w_rsz & (w_rsz - 4'd1)) == 4'd0);
    assign w_req_mis = ~w_onehot
                     | (w_rsz[1] & bus.req_addr[0])
                     | (w_rsz[2] & (|bus.req_addr[1:0]))
                     | (w_rsz[3] & (|bus.req_addr[2:0]));
    assign w_req_mmio = (bus.req_addr >= MMIO_BASE)
                      & (bus.req_addr <= MMIO_LIMIT);

    assign w_head_nxt  = r_head + PW'(w_pop);
    assign w_issue_nxt = r_issue + PW'(w_fire | w_byp);
    assign w_infl_nxt  = r_infl + CW'(w_fire) - CW'(w_done);
    assign w_count_nxt = flush ? w_infl_nxt
                       : r_count + CW'(w_push) - CW'(w_pop);
    assign w_tail_nxt  = flush ? w_issue_nxt : r_tail + PW'(w_push);

    // next bus request, forwarded from the input when it lands in that slot
    logic              w_fwd, w_bv, w_bbyp, w_bload;
    logic [ADDR_W-1:0] w_baddr;
    logic [63:0]       w_bwd, w_bmask_base;
    logic [3:0]        w_bsz;
    logic [5:0]        w_bsh;

    assign w_fwd   = w_push & (w_issue_nxt == r_tail);
    assign w_baddr = w_fwd ? bus.req_addr : r_addr[w_issue_nxt];
    assign w_bwd   = w_fwd ? bus.req_wdata : r_wdata[w_issue_nxt];
    assign w_bsz   = w_fwd ? bus.req_ls_size : r_size[w_issue_nxt];
    assign w_bload = w_fwd ? (bus.req_is_load & ~bus.req_is_store)
                   : r_load[w_issue_nxt];
    assign w_bbyp  = w_fwd ? (w_req_mmio | w_req_mis)
                   : (r_mmio[w_issue_nxt] | r_mis[w_issue_nxt]);
    assign w_bv    = (w_count_nxt != w_infl_nxt) & ~w_bbyp;
    assign w_bsh   = {w_baddr[2:0], 3'b000};
    assign w_bmask_base = ({64{w_bsz[0]}} & 64'hFF)
                        | ({64{w_bsz[1]}} & 64'hFFFF)
                        | ({64{w_bsz[2]}} & 64'hFFFF_FFFF)
                        | ({64{w_bsz[3]}} & {64{1'b1}});

    logic [63:0] w_rsh, w_ld;
    logic [3:0]  w_hsz;
    logic        w_sx;

    assign w_hsz = r_size[r_head];
    assign w_sx  = ~r_uns[r_head];
    assign w_rsh = bus.tbus_read_data >> {r_addr[r_head][2:0], 3'b000};
    assign w_ld  = ({64{w_hsz[0]}} & {{56{w_sx & w_rsh[7]}}, w_rsh[7:0]})
                 | ({64{w_hsz[1]}} & {{48{w_sx & w_rsh[15]}}, w_rsh[15:0]})
                 | ({64{w_hsz[2]}} & {{32{w_sx & w_rsh[31]}}, w_rsh[31:0]})
                 | ({64{w_hsz[3]}} & w_rsh);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_tail]  <= bus.req_addr;
            r_wdata[r_tail] <= bus.req_wdata;
            r_tag[r_tail]   <= bus.req_tag;
            r_size[r_tail]  <= bus.req_ls_size;
            r_load[r_tail]  <= bus.req_is_load & ~bus.req_is_store;
            r_uns[r_tail]   <= bus.req_is_unsigned;
            r_mmio[r_tail]  <= w_req_mmio;
            r_mis[r_tail]   <= w_req_mis;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_issue <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_infl  <= '0;
            r_bv    <= 1'b0;
            r_bidx  <= '0;
            r_bop   <= '0;
            r_bdata <= '0;
            r_bmask <= '0;
            r_rv    <= 1'b0;
            r_rtag  <= '0;
            r_rdata <= '0;
            r_rmmio <= 1'b0;
            r_rmis  <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_issue <= w_issue_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_infl  <= w_infl_nxt;
            r_bv    <= w_bv;
            r_bidx  <= w_bv ? w_baddr : '0;
            r_bop   <= ~w_bv ? '0 : (w_bload ? `TBUS_READ : `TBUS_WRITE);
            r_bdata <= w_bv ? (w_bwd << w_bsh) : '0;
            r_bmask <= w_bv ? (w_bmask_base << w_bsh) : '0;
            r_rv    <= w_pop;
            r_rtag  <= w_pop ? r_tag[r_head] : '0;
            r_rdata <= (w_done & r_load[r_head]) ? w_ld : '0;
            r_rmmio <= w_byp & r_mmio[r_head] & ~r_mis[r_head];
            r_rmis  <= w_byp & r_mis[r_head];
        end
    end

    assign bus.tbus_index_valid    = r_bv;
    assign bus.tbus_index          = r_bidx;
    assign bus.tbus_operation_type = r_bop;
    assign bus.tbus_write_data     = r_bdata;
    assign bus.tbus_write_mask     = r_bmask;
    assign bus.resp_valid          = r_rv;
    assign bus.resp_tag            = r_rtag;
    assign bus.resp_data           = r_rdata;
    assign bus.resp_mmio           = r_rmmio;
    assign bus.resp_misalign       = r_rmis;
    assign busy = (r_count != '0) | r_rv;
endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed bench for lsu_req_queue: expected bus ops and responses are
// queued at issue time and popped by independent monitors.
module tb_lsu_req_queue;
    localparam int AW = 64;
    localparam int TW = 6;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    lsu_req_queue_if #(.ADDR_W(AW), .TAG_W(TW)) bus ();

    lsu_req_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .busy(busy),
        .bus(bus)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [63:0]   data;
        logic          mmio;
        logic          mis;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    op;
        logic          lanes;
        logic [63:0]   mask;
        logic [63:0]   data;
    } bop_t;

    resp_t exp_r[$];
    bop_t  exp_b[$];
    int total = 0;
    int bad = 0;
    int fires = 0;
    int resps = 0;
    int exp_fires = 0;
    int exp_resps = 0;

    resp_t mr;
    always @(negedge clock) begin
        if (reset_n && bus.resp_valid) begin
            resps++;
            total++;
            if (exp_r.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected tag=%0d got a response, required none",
                         bus.resp_tag);
            end else begin
                mr = exp_r.pop_front();
                if (bus.resp_tag !== mr.tag || bus.resp_data !== mr.data ||
                    bus.resp_mmio !== mr.mmio || bus.resp_misalign !== mr.mis) begin
                    bad++;
                    $display("FAIL resp tag=%0d data=%h mmio=%b mis=%b required tag=%0d data=%h mmio=%b mis=%b",
                             bus.resp_tag, bus.resp_data, bus.resp_mmio,
                             bus.resp_misalign, mr.tag, mr.data, mr.mmio, mr.mis);
                end
            end
        end
    end

    bop_t mb;
    always @(negedge clock) begin
        if (reset_n && bus.tbus_index_valid && bus.tbus_index_ready) begin
            fires++;
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected addr=%h got a bus request, required none",
                         bus.tbus_index);
            end else begin
                mb = exp_b.pop_front();
                if (bus.tbus_index !== mb.addr || bus.tbus_operation_type !== mb.op ||
                    (mb.lanes && (bus.tbus_write_mask !== mb.mask ||
                                  bus.tbus_write_data !== mb.data))) begin
                    bad++;
                    $display("FAIL bus addr=%h op=%0d mask=%h data=%h required addr=%h op=%0d mask=%h data=%h",
                             bus.tbus_index, bus.tbus_operation_type,
                             bus.tbus_write_mask, bus.tbus_write_data,
                             mb.addr, mb.op, mb.mask, mb.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // all stimulus tasks start and end 1 time unit after a rising edge
    task automatic push(input logic st, input logic uns, input logic [3:0] sz,
                        input logic [AW-1:0] addr, input logic [63:0] wd,
                        input logic [TW-1:0] tag, input logic on_bus,
                        input logic [63:0] bmask, input logic [63:0] bdata,
                        input logic want, input logic [63:0] rdata,
                        input logic rmmio, input logic rmis);
        int n;
        bop_t b;
        resp_t r;
        if (on_bus) begin
            b.addr = addr;
            b.op = st ? `TBUS_WRITE : `TBUS_READ;
            b.lanes = st;
            b.mask = bmask;
            b.data = bdata;
            exp_b.push_back(b);
            exp_fires++;
        end
        if (want) begin
            r.tag = tag;
            r.data = rdata;
            r.mmio = rmmio;
            r.mis = rmis;
            exp_r.push_back(r);
            exp_resps++;
        end
        bus.req_valid = 1'b1;
        bus.req_is_load = ~st;
        bus.req_is_store = st;
        bus.req_is_unsigned = uns;
        bus.req_ls_size = sz;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        bus.req_tag = tag;
        n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) chk("push_timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic ld(input logic uns, input logic [3:0] sz,
                      input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                      input logic on_bus, input logic [63:0] rdata,
                      input logic rmmio, input logic rmis);
        push(1'b0, uns, sz, addr, 64'd0, tag, on_bus, 64'd0, 64'd0,
             1'b1, rdata, rmmio, rmis);
    endtask

    task automatic done(input logic [63:0] d);
        bus.tbus_operation_done = 1'b1;
        bus.tbus_read_data = d;
        tick(1);
        bus.tbus_operation_done = 1'b0;
        bus.tbus_read_data = 64'd0;
    endtask

    task automatic wait_fires();
        int n = 0;
        while (fires < exp_fires && n < 200) begin
            tick(1);
            n++;
        end
        chk("fire_count", 64'(fires), 64'(exp_fires));
    endtask

    task automatic wait_resps();
        int n = 0;
        while (resps < exp_resps && n < 200) begin
            tick(1);
            n++;
        end
        chk("resp_count", 64'(resps), 64'(exp_resps));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_r.delete();
        exp_b.delete();
        tick(2);
        exp_fires = fires;
        exp_resps = resps;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_is_load = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_is_unsigned = 1'b0;
        bus.req_ls_size = 4'd0;
        bus.req_addr = '0;
        bus.req_wdata = 64'd0;
        bus.req_tag = '0;
        bus.tbus_index_ready = 1'b1;
        bus.tbus_operation_done = 1'b0;
        bus.tbus_read_data = 64'd0;

        do_reset();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_bus_valid", 64'(bus.tbus_index_valid), 64'd0);
        chk("rst_bus_mask", bus.tbus_write_mask, 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick(1);

        // byte loads, signed and unsigned, lane 3
        ld(1'b0, 4'b0001, 64'h8000_0003, 6'd1, 1'b1,
           64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0);
        wait_fires();
        done(64'h0000_0000_8000_0000);
        ld(1'b1, 4'b0001, 64'h8000_0003, 6'd2, 1'b1,
           64'h0000_0000_0000_0080, 1'b0, 1'b0);
        wait_fires();
        done(64'h0000_0000_8000_0000);
        wait_resps();

        // half store at lane 6
        push(1'b1, 1'b0, 4'b0010, 64'h8000_0006, 64'h1234, 6'd3, 1'b1,
             64'hFFFF_0000_0000_0000, 64'h1234_0000_0000_0000,
             1'b1, 64'd0, 1'b0, 1'b0);
        wait_fires();
        done(64'hFFFF_FFFF_FFFF_FFFF);
        wait_resps();

        // fill all entries with loads while dones are held back
        for (int i = 0; i < DEPTH; i++)
            ld(1'b0, 4'b1000, 64'h8000_1000 + 64'(8 * i), TW'(10 + i), 1'b1,
               64'h1111_1111_1111_1111 * 64'(i + 1), 1'b0, 1'b0);
        chk("ready_full", 64'(bus.req_ready), 64'd0);
        wait_fires();
        chk("ready_still_full", 64'(bus.req_ready), 64'd0);
        done(64'h1111_1111_1111_1111);
        chk("ready_after_pop", 64'(bus.req_ready), 64'd1);
        for (int i = 1; i < DEPTH; i++)
            done(64'h1111_1111_1111_1111 * 64'(i + 1));
        wait_resps();

        // MMIO load behind two in-flight loads
        ld(1'b0, 4'b1000, 64'h8000_2000, 6'd20, 1'b1, 64'hA0, 1'b0, 1'b0);
        ld(1'b0, 4'b1000, 64'h8000_2008, 6'd21, 1'b1, 64'hB0, 1'b0, 1'b0);
        ld(1'b0, 4'b0100, 64'h3000_0010, 6'd22, 1'b0, 64'd0, 1'b1, 1'b0);
        wait_fires();
        tick(3);
        chk("mmio_no_bus", 64'(bus.tbus_index_valid), 64'd0);
        chk("mmio_no_early_resp", 64'(resps), 64'(exp_resps - 3));
        done(64'hA0);
        done(64'hB0);
        wait_resps();

        // misalign, illegal size, priority, and MMIO window edges
        ld(1'b0, 4'b0100, 64'h8000_0002, 6'd30, 1'b0, 64'd0, 1'b0, 1'b1);
        ld(1'b0, 4'b0011, 64'h8000_0000, 6'd31, 1'b0, 64'd0, 1'b0, 1'b1);
        ld(1'b0, 4'b0100, 64'h3000_0001, 6'd32, 1'b0, 64'd0, 1'b0, 1'b1);
        ld(1'b0, 4'b0001, 64'h4070_0000, 6'd33, 1'b0, 64'd0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 4'b1000, 64'h3000_0000, 64'h77, 6'd35, 1'b0,
             64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
        ld(1'b0, 4'b0001, 64'h4070_0001, 6'd34, 1'b1,
           64'h0000_0000_0000_007F, 1'b0, 1'b0);
        wait_fires();
        done(64'h0000_0000_0000_7F00);
        wait_resps();

        // done with nothing in flight
        done(64'hDEAD_BEEF);
        tick(3);
        chk("stray_done_busy", 64'(busy), 64'd0);

        // flush with one in flight and two queued
        ld(1'b0, 4'b1000, 64'h8000_3000, 6'd40, 1'b1, 64'h55, 1'b0, 1'b0);
        wait_fires();
        bus.tbus_index_ready = 1'b0;
        push(1'b0, 1'b0, 4'b1000, 64'h8000_3008, 64'd0, 6'd41, 1'b0,
             64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 4'b1000, 64'h8000_3010, 64'd0, 6'd42, 1'b0,
             64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("held_valid", 64'(bus.tbus_index_valid), 64'd1);
        chk("held_index", bus.tbus_index, 64'h8000_3008);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_drop_valid", 64'(bus.tbus_index_valid), 64'd0);
        bus.tbus_index_ready = 1'b1;
        tick(4);
        chk("flush_busy_inflight", 64'(busy), 64'd1);
        done(64'h55);
        wait_resps();
        tick(2);
        chk("flush_busy_idle", 64'(busy), 64'd0);

        // reset mid-operation, then a late done
        ld(1'b0, 4'b1000, 64'h8000_4000, 6'd50, 1'b1, 64'h99, 1'b0, 1'b0);
        wait_fires();
        do_reset();
        chk("midrst_bus_valid", 64'(bus.tbus_index_valid), 64'd0);
        reset_n = 1'b1;
        tick(1);
        done(64'h99);
        tick(3);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd1);

        chk("resp_queue_empty", 64'(exp_r.size()), 64'd0);
        chk("bus_queue_empty", 64'(exp_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
